// File: rtl/config_loader_if.sv
// Host word handshake, serial chain link and readback port of the config loader.
// The master side is the host/chain environment; the slave side is the loader.
interface config_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_out;
  logic              cfg_shift_en;
  logic              cfg_ret;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;

  modport master (
    output in_data, in_valid, cfg_ret,
    input  in_ready, cfg_out, cfg_shift_en, rb_data, rb_valid
  );

  modport slave (
    input  in_data, in_valid, cfg_ret,
    output in_ready, cfg_out, cfg_shift_en, rb_data, rb_valid
  );
endinterface

// File: rtl/config_loader.sv
// Bit-serial configuration streamer: shifts host words LSB-first into a cell chain
// for exactly CHAIN_LEN cycles while capturing the old chain contents as readback.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start, bit counter cleared
// S_WAIT  | in_ready high, waiting for the next host word
// S_SHIFT | chain shifting, one stream bit out / one readback bit in
// S_DONE  | one-cycle done pulse, then back to idle
module config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32
) (
  input  logic            config_clk,
  input  logic            config_reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  config_loader_if.slave  bus
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] rb_sh;
  logic [WORD_W-1:0] rb_next;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     word_idx;
  logic [31:0]       rb_shamt;
  logic              last_bit;
  logic              word_end;

  assign last_bit = (bit_cnt == CW'(CHAIN_LEN - 1));
  assign word_end = (32'(word_idx) == 32'(WORD_W - 1));

  // Readback enters at the MSB end; a short final word is right-aligned on emit.
  assign rb_next  = (rb_sh >> 1) | (WORD_W'(bus.cfg_ret) << (WORD_W - 1));
  assign rb_shamt = 32'(WORD_W - 1) - 32'(word_idx);

  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_WAIT;
      S_WAIT:  if (bus.in_valid) state_d = S_SHIFT;
      S_SHIFT: begin
        if (last_bit)      state_d = S_DONE;
        else if (word_end) state_d = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode registered state so nothing combinational reaches the pins.
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign bus.in_ready     = (state_q == S_WAIT);
  assign bus.cfg_shift_en = (state_q == S_SHIFT);
  assign bus.cfg_out      = (state_q == S_SHIFT) & shreg[0];

  always_ff @(posedge config_clk or negedge config_reset) begin
    if (!config_reset) begin
      shreg        <= '0;
      rb_sh        <= '0;
      bit_cnt      <= '0;
      word_idx     <= '0;
      bus.rb_data  <= '0;
      bus.rb_valid <= 1'b0;
    end else begin
      bus.rb_valid <= 1'b0;
      case (state_q)
        S_IDLE: bit_cnt <= '0;
        S_WAIT: begin
          if (bus.in_valid) begin
            shreg    <= bus.in_data;
            word_idx <= '0;
          end
        end
        S_SHIFT: begin
          shreg    <= shreg >> 1;
          rb_sh    <= rb_next;
          bit_cnt  <= bit_cnt + CW'(1);
          word_idx <= word_idx + CW'(1);
          if (last_bit || word_end) begin
            bus.rb_valid <= 1'b1;
            bus.rb_data  <= rb_next >> rb_shamt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: a 64-bit and a 40-bit chain instance,
// each checked against a stream/readback model computed from the word contents.
module tb_config_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  st;
  logic [1:0]  iv;
  logic [31:0] idt [2];
  logic        busy0, busy1, done0, done1;

  config_loader_if #(.WORD_W(32)) bus0();
  config_loader_if #(.WORD_W(32)) bus1();

  logic [63:0] chain0;
  logic [39:0] chain1;
  logic [1:0]  pl_req;
  logic [63:0] pl_val;
  logic [1:0]  clr;

  assign bus0.in_valid = iv[0];
  assign bus0.in_data  = idt[0];
  assign bus1.in_valid = iv[1];
  assign bus1.in_data  = idt[1];
  assign bus0.cfg_ret  = chain0[0];
  assign bus1.cfg_ret  = chain1[0];

  config_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut0 (
    .config_clk(clk), .config_reset(rst_n), .start(st[0]),
    .busy(busy0), .done(done0), .bus(bus0)
  );

  config_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut1 (
    .config_clk(clk), .config_reset(rst_n), .start(st[1]),
    .busy(busy1), .done(done1), .bus(bus1)
  );

  logic [1:0]  se, co, rv, dn, ir, bz;
  logic [31:0] rd [2];
  assign se    = {bus1.cfg_shift_en, bus0.cfg_shift_en};
  assign co    = {bus1.cfg_out, bus0.cfg_out};
  assign rv    = {bus1.rb_valid, bus0.rb_valid};
  assign ir    = {bus1.in_ready, bus0.in_ready};
  assign dn    = {done1, done0};
  assign bz    = {busy1, busy0};
  assign rd[0] = bus0.rb_data;
  assign rd[1] = bus1.rb_data;

  // Behavioural chains: head stage is the top bit, tail (cfg_ret) is bit 0.
  always @(posedge clk) begin
    if (pl_req[0])   chain0 <= pl_val;
    else if (se[0])  chain0 <= {co[0], chain0[63:1]};
    if (pl_req[1])   chain1 <= pl_val[39:0];
    else if (se[1])  chain1 <= {co[1], chain1[39:1]};
  end

  int          cyc = 0;
  logic [63:0] sbits [2];
  int          scnt  [2];
  logic [31:0] rbw   [2][4];
  int          rbc   [2][4];
  int          rbn   [2];
  int          donec [2];
  int          donen [2];
  int          irn   [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Sampled just before each edge: records what the cycle ending now showed.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clr[d]) begin
        sbits[d] = '0; scnt[d] = 0; rbn[d] = 0; donen[d] = 0; irn[d] = 0;
      end else begin
        if (se[d]) begin
          if (scnt[d] < 64) sbits[d][scnt[d]] = co[d];
          scnt[d] = scnt[d] + 1;
        end
        if (rv[d]) begin
          if (rbn[d] < 4) begin
            rbw[d][rbn[d]] = rd[d];
            rbc[d][rbn[d]] = cyc;
          end
          rbn[d] = rbn[d] + 1;
        end
        if (dn[d]) begin
          if (donen[d] == 0) donec[d] = cyc;
          donen[d] = donen[d] + 1;
        end
        if (ir[d]) irn[d] = irn[d] + 1;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int d, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [63:0] pre, input int stall, input bit glitch,
                         input int abort_at);
    int          len, k, m, sl, bound, nb;
    bit          glitched;
    logic [31:0] w [2];
    logic [63:0] old, es;
    logic [31:0] er;
    len = (d == 1) ? 40 : 64;
    w[0] = w0; w[1] = w1;
    @(negedge clk);
    pl_val = pre; pl_req[d] = 1'b1; clr[d] = 1'b1;
    @(negedge clk);
    pl_req[d] = 1'b0; clr[d] = 1'b0;
    old = (d == 1) ? {24'b0, chain1} : chain0;
    st[d] = 1'b1;
    k = cyc;
    m = 0; sl = stall; bound = 0; glitched = 1'b0;
    while (donen[d] == 0 && bound < 400) begin
      @(negedge clk);
      bound++;
      st[d] = 1'b0;
      if (abort_at >= 0 && scnt[d] == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(bz), 64'd0);
        chk("rst_shift_en", 64'(se), 64'd0);
        chk("rst_cfg_out", 64'(co), 64'd0);
        chk("rst_in_ready", 64'(ir), 64'd0);
        chk("rst_done", 64'(dn), 64'd0);
        chk("rst_rb_valid", 64'(rv), 64'd0);
        chk("rst_rb_data0", 64'(rd[0]), 64'd0);
        chk("rst_rb_data1", 64'(rd[1]), 64'd0);
        iv[d] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 64'(bz), 64'd0);
        chk("no_ready_after_reset", 64'(ir), 64'd0);
        return;
      end
      if (glitch && !glitched && se[d]) begin
        st[d] = 1'b1;
        glitched = 1'b1;
      end
      if (ir[d] && m < 2) begin
        if (m == 1 && sl > 0) begin
          iv[d] = 1'b0;
          sl--;
        end else begin
          iv[d] = 1'b1;
          idt[d] = w[m];
          m++;
        end
      end else begin
        iv[d] = 1'b0;
      end
    end
    st[d] = 1'b0;
    iv[d] = 1'b0;
    chk("done_seen", 64'(donen[d] != 0), 64'd1);
    repeat (8) @(negedge clk);

    es = '0;
    for (int i = 0; i < len; i++) es[i] = w[i / 32][i % 32];
    nb = (len < 64) ? len : 64;
    chk("shift_count", 64'(scnt[d]), 64'(len));
    chk("cfg_out_stream", sbits[d], es);
    chk("chain_contents", (d == 1) ? {24'b0, chain1} : chain0, es);
    chk("done_cycle", 64'(donec[d]), 64'(k + 3 + stall + len));
    chk("done_count", 64'(donen[d]), 64'd1);
    chk("ready_cycles", 64'(irn[d]), 64'(2 + stall));
    chk("rb_count", 64'(rbn[d]), 64'd2);
    for (int j = 0; j < 2; j++) begin
      er = '0;
      for (int b = 0; b < 32; b++)
        if (j * 32 + b < nb) er[b] = old[j * 32 + b];
      chk("rb_word", 64'(rbw[d][j]), 64'(er));
      chk("rb_cycle", 64'(rbc[d][j]),
          64'(k + 2 + j + ((j == 1) ? stall : 0) + ((32 * (j + 1) < len) ? 32 * (j + 1) : len)));
    end
    chk("idle_after_load", 64'(bz[d]), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; st = '0; iv = '0; idt[0] = '0; idt[1] = '0;
    clr = '0; pl_req = '0; pl_val = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bz), 64'd0);
    chk("reset_done", 64'(dn), 64'd0);
    chk("reset_in_ready", 64'(ir), 64'd0);
    chk("reset_shift_en", 64'(se), 64'd0);
    chk("reset_cfg_out", 64'(co), 64'd0);
    chk("reset_rb_valid", 64'(rv), 64'd0);
    chk("reset_rb_data", {rd[1], rd[0]}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_load(0, 32'hA5A5_0F0F, 32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0, -1);
    chk("rb_directed_w0", 64'(rbw[0][0]), 64'hCAFE_F00D);
    chk("rb_directed_w1", 64'(rbw[0][1]), 64'hDEAD_BEEF);

    do_load(0, $urandom, $urandom, {$urandom, $urandom}, 5, 1'b0, -1);
    do_load(0, $urandom, $urandom, {$urandom, $urandom}, 0, 1'b1, -1);
    do_load(1, 32'hFFFF_FFFF, 32'h0000_00AB, {$urandom, $urandom}, 0, 1'b0, -1);
    chk("partial_rb_high_zero", 64'(rbw[1][1] >> 8), 64'd0);

    do_load(0, $urandom, $urandom, {$urandom, $urandom}, 0, 1'b0, 20);
    do_load(0, $urandom, $urandom, {$urandom, $urandom}, 0, 1'b0, -1);

    for (int t = 0; t < 6; t++)
      do_load(int'($urandom_range(1, 0)), $urandom, $urandom, {$urandom, $urandom},
              int'($urandom_range(3, 0)), 1'(t % 2), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Bit-serial configuration streamer that sits directly upstream of every configurable cell chain in the fabric (switch cells, FU cells). It accepts configuration words from the host over a valid/ready handshake and serializes them, LSB first, onto the chain's serial config input for exactly `CHAIN_LEN` shift cycles. It produces a shift-enable that the integration uses to gate the chain clock. The bits returning from the chain tail are captured and handed back as readback words, so the previous chain contents can be checked.

## Interface
- `CHAIN_LEN`, default 64: total configuration bits in the downstream chain, must be ≥ 1.
- `WORD_W`, default 32: host word width, must be ≥ 1.
- `config_clk` input, 1 bit: the single clock. All flops are on the rising edge.
- `config_reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a load. Sampled only in IDLE.
- `busy` output, 1 bit: high in any state other than IDLE.
- `done` output, 1 bit: one-cycle pulse when the load completes.
- `in_data` input, `WORD_W` bits: configuration word.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the loader accepts a word this cycle.
- `cfg_out` output, 1 bit: serial bit to the chain's `config_in`.
- `cfg_shift_en` output, 1 bit: chain shifts on this edge. Gates the chain's `config_clk`.
- `cfg_ret` input, 1 bit: from the chain tail's `config_out`.
- `rb_data` output, `WORD_W` bits: readback word.
- `rb_valid` output, 1 bit: one-cycle pulse. There is no backpressure on readback.

## Operation
- States:
  - **IDLE**: `start` moves to WAIT. Clears `bit_cnt`.
  - **WAIT**: `in_ready` is 1. On `in_valid && in_ready`, load `shreg <= in_data`, clear `word_idx`, and move to SHIFT.
  - **SHIFT**: `cfg_shift_en` is 1 and `cfg_out` is `shreg[0]`. Every cycle:
    - shift `shreg` right by one;
    - shift `cfg_ret` into the readback register at MSB-end, so it assembles LSB first;
    - increment `bit_cnt` and `word_idx`.
  - **Leaving SHIFT**:
    - If this is shift cycle `CHAIN_LEN-1` (the last one), go to DONE.
    - Otherwise, if `word_idx == WORD_W-1`, go to WAIT.
    - Otherwise stay in SHIFT.
  - **DONE**: one cycle with `done` = 1, then IDLE.
- Stream bit `i` is `in_data[i % WORD_W]` of word `i / WORD_W`. Host must supply `ceil(CHAIN_LEN/WORD_W)` words.
- Unused high bits of the final word are discarded and never shifted.
- After the load, stream bit 0 sits in the chain stage driving `cfg_ret`, and stream bit `CHAIN_LEN-1` sits in the stage nearest the loader.
- Readback bit `j` is the value of `cfg_ret` sampled at the edge ending shift cycle `j`, i.e. the old chain content.
  - `rb_valid` pulses the cycle after each `WORD_W`-th captured bit, and after the final bit.
  - A final partial word is right-aligned, with its high bits zero.
- `cfg_out`, `cfg_shift_en`, `in_ready`, `busy`, `done`, `rb_valid` and `rb_data` are driven from flops or from a decode of registered state only. No input-to-output combinational path.
- `start` in any state other than IDLE is ignored.
- Counter width is `$clog2(CHAIN_LEN+1)`. Counters never wrap during a load.

## Timing
- Reset values (asynchronous, while `config_reset` = 0): state IDLE; all outputs 0; `shreg`, the readback register and the counters 0.
- Reset mid-load aborts immediately. Chain contents are then undefined and the host must reload.
- With `start` sampled at edge k:
  - WAIT occupies cycle k+1.
  - Each accepted word costs 1 WAIT cycle plus up to `WORD_W` SHIFT cycles.
  - WAIT stretches while `in_valid` = 0; `cfg_shift_en` stays 0 throughout, so the chain holds.
- Defaults with `in_valid` held high:
  - SHIFT k+2..k+33, WAIT k+34, SHIFT k+35..k+66.
  - `done` at k+67.
  - `rb_valid` at k+34 and k+67.
- `in_ready` is never high outside WAIT. A word is consumed only on the cycle `in_valid` and `in_ready` are both high.
- `done` and the final `rb_valid` coincide.

## Test plan
- **Full load, defaults:** after reset, pulse `start` and supply 0xA5A5_0F0F then 0x1234_5678 with `in_valid` high.
  - Exactly 64 `cfg_shift_en` cycles.
  - `cfg_out` sequence equals the stream bits LSB-first.
  - `done` at k+67.
  - A behavioral 64-bit chain model holds the stream.
- **Readback:** pre-load the chain model with 0xDEAD_BEEF_CAFE_F00D, then load.
  - `rb_data` = 0xCAFE_F00D at k+34 and 0xDEAD_BEEF at k+67.
- **Stalls:** deassert `in_valid` for 5 cycles before word 1.
  - WAIT lasts 6 cycles, with `cfg_shift_en` 0 and the chain model unchanged.
  - `done` at k+72.
- **Partial word:** `CHAIN_LEN`=40, `WORD_W`=32, words 0xFFFF_FFFF and 0x0000_00AB.
  - 40 shifts; bits 8..31 of word 1 are never driven.
  - The final `rb_data` is zero above bit 7.
  - `done` the cycle after shift 39.
- **Ignored start:** pulse `start` during SHIFT.
  - No effect: counts and `done` timing are unchanged, and no second load follows.
- **Reset mid-load:** drop `config_reset` at shift cycle 20.
  - All outputs are 0 asynchronously.
  - After release the loader is in IDLE, and a fresh load completes correctly.
